// File: rtl/abp_frame_gen_if.sv
// AXI-Stream transmit channel plus ABP hyperdata handshake used by abp_frame_gen.
// master: the framer side (drives the stream and the hyperdata accept).
// slave:  the environment side (MAC sink and hyperdata source).
interface abp_frame_gen_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VALUE_SIZE = 4
);
  logic                      m_eth_tx_tvalid;
  logic [DATA_WIDTH-1:0]     m_eth_tx_tdata;
  logic [DATA_WIDTH/8-1:0]   m_eth_tx_tkeep;
  logic                      m_eth_tx_tlast;
  logic                      m_eth_tx_tready;
  logic                      s_abp_ready;
  logic                      s_abp_valid;
  logic [8*VALUE_SIZE-1:0]   s_abp_value;
  logic                      s_abp_bit;

  modport master (
    output m_eth_tx_tvalid, m_eth_tx_tdata, m_eth_tx_tkeep, m_eth_tx_tlast, s_abp_ready,
    input  m_eth_tx_tready, s_abp_valid, s_abp_value, s_abp_bit
  );

  modport slave (
    input  m_eth_tx_tvalid, m_eth_tx_tdata, m_eth_tx_tkeep, m_eth_tx_tlast, s_abp_ready,
    output m_eth_tx_tready, s_abp_valid, s_abp_value, s_abp_bit
  );
endinterface

// File: rtl/abp_frame_gen.sv
// ABP transmit framer: latches one (value, alternating bit) record per frame and streams a
// PACKET_SIZE-byte frame over AXI-Stream, DATA_WIDTH bits per beat, with tkeep, backpressure,
// mid-frame abort and a completed-frame counter.
// Optional feature: define ABP_TX_CSUM_EN to replace the final frame byte with the XOR of all
// preceding frame bytes.
module abp_frame_gen #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned VALUE_SIZE  = 4,
  parameter int unsigned PACKET_SIZE = 64,
  parameter logic [7:0]  PAD_BYTE    = 8'h00,
  parameter int unsigned VALUE_INCR  = 1
) (
  input  logic                  aclk,
  input  logic                  resetn,
  abp_frame_gen_if.master       bus,
  input  logic                  abort,
  output logic                  busy,
  output logic                  error_early_termination,
  output logic [31:0]           frame_count
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned BEATS     = (PACKET_SIZE + BYTES - 1) / BYTES;
  localparam int unsigned LastBytes = PACKET_SIZE - (BEATS - 1) * BYTES;
  localparam int unsigned CntW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ValW      = 8 * VALUE_SIZE;

  localparam logic [CntW-1:0]       LastBeat = CntW'(BEATS - 1);
  localparam logic [ValW-1:0]       Incr     = ValW'(VALUE_INCR);
  localparam logic [DATA_WIDTH-1:0] PadBeat  = {BYTES{PAD_BYTE}};

  function automatic logic [BYTES-1:0] mk_last_keep();
    logic [BYTES-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (i < LastBytes) k[i] = 1'b1;
    end
    return k;
  endfunction

  localparam logic [BYTES-1:0] LastKeep = mk_last_keep();

`ifdef ABP_TX_CSUM_EN
  // Pad bytes cancel pairwise in the XOR, so only the parity of their count matters.
  localparam bit PadOdd = ((PACKET_SIZE - VALUE_SIZE - 2) % 2) == 1;

  function automatic logic [7:0] csum(input logic [ValW-1:0] v, input logic b);
    logic [7:0] x;
    x = {7'b0, b};
    for (int unsigned i = 0; i < VALUE_SIZE; i++) x = x ^ v[8*i +: 8];
    if (PadOdd) x = x ^ PAD_BYTE;
    return x;
  endfunction
`endif

  // Byte idx of the frame: big-endian value, then the alternating bit, then padding.
  function automatic logic [7:0] frame_byte(input int unsigned idx, input logic [ValW-1:0] v,
                                            input logic b);
    logic [7:0] r;
    r = PAD_BYTE;
    for (int unsigned i = 0; i < VALUE_SIZE; i++) begin
      if (idx == i) r = v[8*(VALUE_SIZE-1-i) +: 8];
    end
    if (idx == VALUE_SIZE) r = {7'b0, b};
`ifdef ABP_TX_CSUM_EN
    if (idx == PACKET_SIZE - 1) r = csum(v, b);
`endif
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [CntW-1:0] beat,
                                                      input logic [ValW-1:0] v, input logic b);
    logic [DATA_WIDTH-1:0] d;
    int unsigned base;
    d    = '0;
    base = 32'(beat) * BYTES;
    for (int unsigned k = 0; k < BYTES; k++) d[8*k +: 8] = frame_byte(base + k, v, b);
    return d;
  endfunction

  function automatic logic [BYTES-1:0] beat_keep(input logic [CntW-1:0] beat);
    return (beat == LastBeat) ? LastKeep : '1;
  endfunction

  typedef enum logic [1:0] {StIdle, StSend, StTerm} state_e;

  state_e                state_q;
  logic [CntW-1:0]       beat_q;
  logic [ValW-1:0]       val_q;
  logic                  bit_q;
  logic                  abort_q;
  logic                  tvalid_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [BYTES-1:0]      tkeep_q;
  logic                  tlast_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  err_q;
  logic [31:0]           count_q;

  logic [ValW-1:0] next_val;
  logic [CntW-1:0] beat_inc;

  assign next_val = bus.s_abp_value + Incr;
  assign beat_inc = beat_q + 1'b1;

  // Frame FSM; every output is a register so tdata/tkeep/tlast stay put under backpressure.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      val_q    <= '0;
      bit_q    <= 1'b0;
      abort_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ready_q && bus.s_abp_valid) begin
            val_q    <= next_val;
            bit_q    <= bus.s_abp_bit;
            beat_q   <= '0;
            abort_q  <= 1'b0;
            state_q  <= StSend;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            tvalid_q <= 1'b1;
            tdata_q  <= beat_data('0, next_val, bus.s_abp_bit);
            tkeep_q  <= beat_keep('0);
            tlast_q  <= (BEATS == 1);
          end else begin
            ready_q <= 1'b1;
          end
        end
        StSend: begin
          if (bus.m_eth_tx_tready) begin
            if (beat_q == LastBeat) begin
              // Final beat accepted; any pending abort is moot.
              state_q  <= StIdle;
              tvalid_q <= 1'b0;
              tdata_q  <= '0;
              tkeep_q  <= '0;
              tlast_q  <= 1'b0;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
              abort_q  <= 1'b0;
              count_q  <= count_q + 32'd1;
            end else if (abort_q || abort) begin
              state_q <= StTerm;
              abort_q <= 1'b0;
              tdata_q <= PadBeat;
              tkeep_q <= '1;
              tlast_q <= 1'b1;
            end else begin
              beat_q  <= beat_inc;
              tdata_q <= beat_data(beat_inc, val_q, bit_q);
              tkeep_q <= beat_keep(beat_inc);
              tlast_q <= (beat_inc == LastBeat);
            end
          end else if (abort && (beat_q != LastBeat)) begin
            abort_q <= 1'b1;
          end
        end
        StTerm: begin
          if (bus.m_eth_tx_tready) begin
            state_q  <= StIdle;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            err_q    <= 1'b1;
            count_q  <= count_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_eth_tx_tvalid      = tvalid_q;
  assign bus.m_eth_tx_tdata       = tdata_q;
  assign bus.m_eth_tx_tkeep       = tkeep_q;
  assign bus.m_eth_tx_tlast       = tlast_q;
  assign bus.s_abp_ready          = ready_q;
  assign busy                     = busy_q;
  assign error_early_termination  = err_q;
  assign frame_count              = count_q;

endmodule

// File: tb/tb_abp_frame_gen.sv
// Bench for abp_frame_gen: an 8-bit/64-byte instance checked every cycle against a frame-level
// model, plus a 64-bit/60-byte instance checked on one frame. Honours ABP_TX_CSUM_EN.
module tb_abp_frame_gen;

  logic aclk = 1'b0;
  logic resetn = 1'b0;
  always #5 aclk = ~aclk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- DUT instances ----------------
  abp_frame_gen_if #(.DATA_WIDTH(8), .VALUE_SIZE(4)) if8 ();
  abp_frame_gen_if #(.DATA_WIDTH(64), .VALUE_SIZE(4)) if64 ();

  logic        abort8 = 1'b0, busy8, err8;
  logic [31:0] cnt8;
  logic        abort64 = 1'b0, busy64, err64;
  logic [31:0] cnt64;

  abp_frame_gen #(.DATA_WIDTH(8), .VALUE_SIZE(4), .PACKET_SIZE(64), .PAD_BYTE(8'h00),
                  .VALUE_INCR(1)) dut8 (
    .aclk(aclk), .resetn(resetn), .bus(if8.master), .abort(abort8), .busy(busy8),
    .error_early_termination(err8), .frame_count(cnt8)
  );

  abp_frame_gen #(.DATA_WIDTH(64), .VALUE_SIZE(4), .PACKET_SIZE(60), .PAD_BYTE(8'h00),
                  .VALUE_INCR(1)) dut64 (
    .aclk(aclk), .resetn(resetn), .bus(if64.master), .abort(abort64), .busy(busy64),
    .error_early_termination(err64), .frame_count(cnt64)
  );

  // ---------------- frame model ----------------
  typedef logic [7:0] bq_t[$];

  function automatic bq_t model_frame(input logic [31:0] v, input logic b, input int ps);
    bq_t fr;
    logic [31:0] s;
    logic [7:0] x;
    s = v + 32'd1;
    fr.push_back(s[31:24]);
    fr.push_back(s[23:16]);
    fr.push_back(s[15:8]);
    fr.push_back(s[7:0]);
    fr.push_back({7'b0, b});
    while (fr.size() < ps) fr.push_back(8'h00);
`ifdef ABP_TX_CSUM_EN
    x = 8'h00;
    for (int i = 0; i < ps - 1; i++) x = x ^ fr[i];
    fr[ps-1] = x;
`else
    x = 8'h00;
`endif
    return fr;
  endfunction

  typedef struct packed {logic [7:0] d; logic l; logic t;} beat_t;
  beat_t       exp_q[$];
  logic [31:0] cnt_exp = 0;
  logic        err_exp = 1'b0;
  logic        rdy_exp = 1'b0;
  logic        abort_st = 1'b0;
  logic [7:0]  got8[$];

  // Per-cycle compare of the 8-bit instance against the model, then model update.
  always @(negedge aclk) begin
    beat_t h;
    bq_t   fr;
    if (!resetn) begin
      chk("rst_tvalid", if8.m_eth_tx_tvalid, 0);
      chk("rst_tdata", if8.m_eth_tx_tdata, 0);
      chk("rst_tkeep", if8.m_eth_tx_tkeep, 0);
      chk("rst_tlast", if8.m_eth_tx_tlast, 0);
      chk("rst_ready", if8.s_abp_ready, 0);
      chk("rst_busy", busy8, 0);
      chk("rst_err", err8, 0);
      chk("rst_count", cnt8, 0);
      exp_q.delete();
      cnt_exp  = 0;
      err_exp  = 1'b0;
      rdy_exp  = 1'b0;
      abort_st = 1'b0;
    end else begin
      chk("tvalid", if8.m_eth_tx_tvalid, exp_q.size() != 0);
      chk("busy", busy8, exp_q.size() != 0);
      if (exp_q.size() != 0 && if8.m_eth_tx_tvalid) begin
        chk("tdata", if8.m_eth_tx_tdata, exp_q[0].d);
        chk("tlast", if8.m_eth_tx_tlast, exp_q[0].l);
        chk("tkeep", if8.m_eth_tx_tkeep, 1);
      end
      chk("s_abp_ready", if8.s_abp_ready, rdy_exp);
      chk("error_pulse", err8, err_exp);
      chk("frame_count", cnt8, cnt_exp);

      err_exp = 1'b0;
      if (exp_q.size() != 0 && !exp_q[0].t && !exp_q[0].l && abort8) abort_st = 1'b1;
      if (if8.m_eth_tx_tvalid && if8.m_eth_tx_tready && exp_q.size() != 0) begin
        h = exp_q.pop_front();
        got8.push_back(if8.m_eth_tx_tdata);
        if (h.l) begin
          cnt_exp  = cnt_exp + 1;
          err_exp  = h.t;
          abort_st = 1'b0;
        end else if (abort_st) begin
          exp_q.delete();
          exp_q.push_back('{d: 8'h00, l: 1'b1, t: 1'b1});
          abort_st = 1'b0;
        end
      end
      if (if8.s_abp_ready && if8.s_abp_valid) begin
        fr = model_frame(if8.s_abp_value, if8.s_abp_bit, 64);
        for (int i = 0; i < 64; i++) exp_q.push_back('{d: fr[i], l: (i == 63), t: 1'b0});
      end
      rdy_exp = (exp_q.size() == 0);
    end
  end

  // ---------------- driver helpers ----------------
  int err_cnt = 0;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic send8(input logic [31:0] v, input logic b);
    int c = 0;
    if8.s_abp_value = v;
    if8.s_abp_bit   = b;
    if8.s_abp_valid = 1'b1;
    @(negedge aclk);
    while (!if8.s_abp_ready && c < 200) begin
      @(negedge aclk);
      c++;
    end
    chk("accept_in_time", c < 200, 1);
    @(posedge aclk);
    #1;
    if8.s_abp_valid = 1'b0;
    if8.s_abp_value = $urandom();
    if8.s_abp_bit   = ~b;
  endtask

  task automatic run_until(input logic [31:0] target, input bit toggle);
    int c = 0;
    while (cnt8 != target && c < 2000) begin
      @(posedge aclk);
      #1;
      c++;
      if (err8) err_cnt++;
      if (toggle) if8.m_eth_tx_tready = pat[c % 4];
    end
    chk("frame_done_in_time", cnt8, target);
    if8.m_eth_tx_tready = 1'b1;
  endtask

  task automatic wait_beats(input int n);
    int c = 0;
    while (got8.size() < n && c < 500) begin
      @(posedge aclk);
      #1;
      c++;
    end
    chk("reach_beat", got8.size(), n);
  endtask

  logic [63:0] d64[16];
  logic [7:0]  k64[16];
  logic        l64[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  initial begin
    bq_t fr;
    int  n;
    bit  done;
    logic [63:0] ed, mask;

    if8.m_eth_tx_tready  = 1'b1;
    if8.s_abp_valid      = 1'b0;
    if8.s_abp_value      = '0;
    if8.s_abp_bit        = 1'b0;
    if64.m_eth_tx_tready = 1'b1;
    if64.s_abp_valid     = 1'b0;
    if64.s_abp_value     = '0;
    if64.s_abp_bit       = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst64_tvalid", if64.m_eth_tx_tvalid, 0);
    chk("rst64_tkeep", if64.m_eth_tx_tkeep, 0);
    chk("rst64_ready", if64.s_abp_ready, 0);
    chk("rst64_count", cnt64, 0);
    resetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // 1: basic frame, value 0x10 bit 1
    got8.delete();
    send8(32'h0000_0010, 1'b1);
    run_until(1, 0);
    chk("t1_len", got8.size(), 64);
    if (got8.size() == 64) begin
      chk("t1_b0", got8[0], 8'h00);
      chk("t1_b3", got8[3], 8'h11);
      chk("t1_b4", got8[4], 8'h01);
      chk("t1_b5", got8[5], 8'h00);
`ifdef ABP_TX_CSUM_EN
      chk("t1_b63", got8[63], 8'h10);
`else
      chk("t1_b63", got8[63], 8'h00);
`endif
    end

    // 6: checksum byte for value 0x01020304 bit 1
    @(posedge aclk);
    #1;
    got8.delete();
    send8(32'h0102_0304, 1'b1);
    run_until(2, 0);
    chk("t6_len", got8.size(), 64);
    if (got8.size() == 64) begin
      chk("t6_b3", got8[3], 8'h05);
`ifdef ABP_TX_CSUM_EN
      chk("t6_csum", got8[63], 8'h04);
`else
      chk("t6_b63", got8[63], 8'h00);
`endif
    end

    // 3: backpressure pattern 1,0,0,1
    got8.delete();
    send8(32'hDEAD_BEEF, 1'b0);
    run_until(3, 1);
    chk("t3_len", got8.size(), 64);
    if (got8.size() == 64) chk("t3_b3", got8[3], 8'hF0);

    // 4: abort while beat 10 is presented
    got8.delete();
    err_cnt = 0;
    send8(32'h0000_0100, 1'b0);
    wait_beats(10);
    abort8 = 1'b1;
    @(posedge aclk);
    #1;
    abort8 = 1'b0;
    run_until(4, 0);
    chk("t4_len", got8.size(), 12);
    if (got8.size() == 12) chk("t4_pad", got8[11], 8'h00);
    chk("t4_err_cycles", err_cnt, 1);
    @(posedge aclk);
    #1;
    chk("t4_err_cleared", err8, 0);
    chk("t4_ready_back", if8.s_abp_ready, 1);

    // Abort in idle, then abort on the final beat: both ignored
    abort8 = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    abort8 = 1'b0;
    got8.delete();
    err_cnt = 0;
    send8(32'h0000_0200, 1'b1);
    wait_beats(63);
    abort8 = 1'b1;
    @(posedge aclk);
    #1;
    abort8 = 1'b0;
    run_until(5, 0);
    chk("final_abort_len", got8.size(), 64);
    chk("final_abort_err", err_cnt, 0);

    // 5: reset during beat 20, then a clean frame
    got8.delete();
    send8(32'h1234_5678, 1'b0);
    wait_beats(20);
    resetn = 1'b0;
    #1;
    chk("t5_tvalid_async", if8.m_eth_tx_tvalid, 0);
    chk("t5_tlast_async", if8.m_eth_tx_tlast, 0);
    chk("t5_busy_async", busy8, 0);
    chk("t5_count_async", cnt8, 0);
    repeat (3) @(posedge aclk);
    #1;
    resetn = 1'b1;
    got8.delete();
    send8(32'h1234_5678, 1'b0);
    run_until(1, 0);
    chk("t5_len", got8.size(), 64);
    if (got8.size() == 64) chk("t5_b3", got8[3], 8'h79);

    // 2: 64-bit instance, 60-byte frame, value wraps to 0
    if64.s_abp_value = 32'hFFFF_FFFF;
    if64.s_abp_bit   = 1'b0;
    if64.s_abp_valid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!if64.s_abp_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    chk("t2_accept", n < 50, 1);
    @(posedge aclk);
    #1;
    if64.s_abp_valid = 1'b0;
    if64.s_abp_value = 32'h5555_AAAA;
    n = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge aclk);
      if (if64.m_eth_tx_tvalid && if64.m_eth_tx_tready && n < 16) begin
        d64[n] = if64.m_eth_tx_tdata;
        k64[n] = if64.m_eth_tx_tkeep;
        l64[n] = if64.m_eth_tx_tlast;
        done   = if64.m_eth_tx_tlast;
        n++;
      end
    end
    chk("t2_beats", n, 8);
    if (n == 8) begin
      chk("t2_beat0", d64[0], 64'h0);
      chk("t2_keep7", k64[7], 8'h0F);
      chk("t2_last7", l64[7], 1);
      fr = model_frame(32'hFFFF_FFFF, 1'b0, 60);
      for (int j = 0; j < 8; j++) begin
        ed   = '0;
        mask = '0;
        for (int k = 0; k < 8; k++) begin
          if (8 * j + k < 60) begin
            ed[8*k +: 8]   = fr[8*j+k];
            mask[8*k +: 8] = 8'hFF;
          end
        end
        chk($sformatf("t2_data%0d", j), d64[j] & mask, ed);
        chk($sformatf("t2_keep%0d", j), k64[j], (j == 7) ? 8'h0F : 8'hFF);
        chk($sformatf("t2_last%0d", j), l64[j], j == 7);
      end
    end
    @(posedge aclk);
    #1;
    chk("t2_count", cnt64, 1);
    chk("t2_err", err64, 0);

    repeat (2) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
